sp_ram_sim_model: RTL and testbench

// - Behavioural single-port synchronous RAM with per-column write mask. Used as the

---
 rtl/sp_ram_pkg.sv | 18 +
 rtl/sp_ram_sim_model.sv | 69 ++++++
 tb/tb_sp_ram_sim_model.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sp_ram_pkg.sv
// Shared definitions for the sp_ram family: access encodings and
// an elaboration-time width check for the column write mask.
package sp_ram_pkg;

    localparam logic RAM_WR = 1'b1;
    localparam logic RAM_RD = 1'b0;

    function automatic bit col_width_ok(
        input int unsigned data_width,
        input int unsigned col_width
    );
        if (col_width == 0) begin
            return 1'b0;
        end
        return (data_width % col_width) == 0;
    endfunction

endpackage

// File: rtl/sp_ram_sim_model.sv
// Behavioural single-port synchronous RAM with per-column write mask,
// shaped so FPGA tools infer byte-write block RAM.
module sp_ram_sim_model
    import sp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter int COL_WIDTH  = 1,
    localparam int NUM_COL   = DATA_WIDTH / COL_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CE,
    input  logic                  RDWEN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] DI,
    input  logic [NUM_COL-1:0]    BW,
    output logic [DATA_WIDTH-1:0] DO
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (!col_width_ok(DATA_WIDTH, COL_WIDTH)) begin : g_bad_width
        $fatal(1, "sp_ram_sim_model: DATA_WIDTH %0d not a multiple of COL_WIDTH %0d",
               DATA_WIDTH, COL_WIDTH);
    end

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] do_d;
    logic [DATA_WIDTH-1:0] do_q;

    always_comb begin
        wr_en = CE && (RDWEN == RAM_WR);
        rd_en = CE && (RDWEN == RAM_RD);
    end

    // No reset on the array: a write coinciding with RST still lands.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int i = 0; i < NUM_COL; i++) begin
                if (BW[i]) begin
                    mem[A][i*COL_WIDTH +: COL_WIDTH] <= DI[i*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
    end

    // No-change output: writes and idle cycles leave DO untouched.
    always_comb begin
        do_d = do_q;
        if (rd_en) begin
            do_d = mem[A];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            do_q <= '0;
        end else begin
            do_q <= do_d;
        end
    end

    assign DO = do_q;

endmodule

// File: tb/tb_sp_ram_sim_model.sv
// Directed bench for sp_ram_sim_model at AW=4, DW=32, CW=8.
// Inputs change 1ns after the rising edge; DO is sampled at the same point.
module tb_sp_ram_sim_model;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NC = DW / CW;

    logic          clk;
    logic          rst;
    logic          ce;
    logic          rdwen;
    logic [AW-1:0] a;
    logic [DW-1:0] di;
    logic [NC-1:0] bw;
    logic [DW-1:0] dout;

    int n_tot;
    int n_bad;

    sp_ram_sim_model #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .COL_WIDTH (CW)
    ) u_dut (
        .CLK  (clk),
        .RST  (rst),
        .CE   (ce),
        .RDWEN(rdwen),
        .A    (a),
        .DI   (di),
        .BW   (bw),
        .DO   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic c, input logic w, input logic [AW-1:0] ad,
                       input logic [DW-1:0] d, input logic [NC-1:0] m);
        ce    = c;
        rdwen = w;
        a     = ad;
        di    = d;
        bw    = m;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] ad, input logic [DW-1:0] d,
                      input logic [NC-1:0] m);
        cyc(1'b1, 1'b1, ad, d, m);
    endtask

    task automatic rd(input logic [AW-1:0] ad);
        cyc(1'b1, 1'b0, ad, '0, '0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        n_tot = 0;
        n_bad = 0;
        rst   = 1'b1;
        ce    = 1'b0;
        rdwen = 1'b0;
        a     = '0;
        di    = '0;
        bw    = '0;
        @(posedge clk);
        #1;
        check("reset_do", dout, 32'h0000_0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();

        wr(4'd3, 32'hDEAD_BEEF, 4'hF);
        check("do_after_write", dout, 32'h0000_0000);
        rd(4'd3);
        check("full_write_rd", dout, 32'hDEAD_BEEF);

        wr(4'd3, 32'h1122_3344, 4'b0101);
        check("no_write_thru", dout, 32'hDEAD_BEEF);
        rd(4'd3);
        check("partial_write", dout, 32'hDE22_BE44);

        cyc(1'b0, 1'b1, 4'd3, 32'hFFFF_FFFF, 4'hF);
        check("ce0_do_hold", dout, 32'hDE22_BE44);
        wr(4'd3, 32'h0000_0000, 4'h0);
        rd(4'd3);
        check("ce0_bw0_nochg", dout, 32'hDE22_BE44);

        wr(4'd5, 32'h0000_0000, 4'hF);
        check("wr_hold_during", dout, 32'hDE22_BE44);
        idle();
        check("wr_hold_after", dout, 32'hDE22_BE44);
        rd(4'd5);
        check("rd_a5_zero", dout, 32'h0000_0000);

        rd(4'd3);
        check("rd_before_rst", dout, 32'hDE22_BE44);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_do", dout, 32'h0000_0000);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rd(4'd3);
        check("rd_after_rst", dout, 32'hDE22_BE44);

        // reset asserted over a write edge: array still takes the write
        rst = 1'b1;
        wr(4'd7, 32'hAAAA_5555, 4'hF);
        check("rst_wr_do", dout, 32'h0000_0000);
        rd(4'd7);
        check("rst_beats_rd", dout, 32'h0000_0000);
        rst = 1'b0;
        rd(4'd7);
        check("wr_under_rst", dout, 32'hAAAA_5555);

        for (int i = 0; i < (1 << AW); i++) begin
            wr(AW'(i), 32'h0101_0101 * i, 4'hF);
        end
        for (int i = 0; i < (1 << AW); i++) begin
            rd(AW'(i));
            check($sformatf("sweep_%0d", i), dout, 32'h0101_0101 * i);
        end
        rd(4'd15);
        check("sweep_top", dout, 32'h0F0F_0F0F);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
